// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, functs,
// ALU commands, mux select codes and FSM state numbering.
package cpu_ctrl_pkg;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnJr  = 6'b001000;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluXor = 3'b010,
    AluSlt = 3'b011
  } alu_cmd_e;

  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcRs     = 2'b11;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StRwb     = 4'd3,
    StExecI   = 4'd4,
    StIwb     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StLwb     = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJal     = 4'd12,
    StJr      = 4'd13,
    StTrap    = 4'd14
  } state_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned RET_CNT_W = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_wr_en;
  logic                 ir_wr_en;
  logic                 mem_addr_sel;
  logic                 mem_wr_en;
  logic                 reg_wr_en;
  logic                 reg_dest;
  logic                 jal_sel_addr;
  logic                 jal_sel_d;
  logic                 mem_to_reg;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [2:0]           alu_sel;
  logic [1:0]           pc_src;
  logic                 instr_done;
  logic                 trap;
  logic [RET_CNT_W-1:0] retired;
  logic [3:0]           state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_wr_en, ir_wr_en, mem_addr_sel, mem_wr_en, reg_wr_en, reg_dest, jal_sel_addr,
           jal_sel_d, mem_to_reg, alu_src_a, alu_src_b, alu_sel, pc_src, instr_done, trap,
           retired, state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_wr_en, ir_wr_en, mem_addr_sel, mem_wr_en, reg_wr_en, reg_dest, jal_sel_addr,
           jal_sel_d, mem_to_reg, alu_src_a, alu_src_b, alu_sel, pc_src, instr_done, trap,
           retired, state_dbg
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the cycle in which the
// stall reaches MEM_TIMEOUT. MEM_TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic count_i,
  output logic timeout_o
);
  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_o = (MEM_TIMEOUT != 0) && count_i && (cnt_q == LastCnt);

  // Leaving a memory state needs mem_ready or a timeout, both of which clear the count.
  always_comb begin
    cnt_d = '0;
    if (count_i && !timeout_o && (MEM_TIMEOUT != 0)) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS-subset datapath; sequences one shared
// memory port, retires instructions and traps on illegal opcodes or stalls.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_CNT_W   = 32
) (
  input logic              clk,
  input logic              reset_n,
  multicycle_ctrl_if.master dp
);
  state_e               state_q, state_d;
  logic [RET_CNT_W-1:0] retired_q;
  logic                 pc_wr, ir_wr, mem_wr, reg_wr;
  logic                 mem_wait, mem_timeout, instr_done;
  alu_cmd_e             alu_cmd;

  assign mem_wait = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr)) &&
                    !dp.mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .count_i  (mem_wait),
    .timeout_o(mem_timeout)
  );

  always_comb begin
    state_d         = state_q;
    pc_wr           = 1'b0;
    ir_wr           = 1'b0;
    mem_wr          = 1'b0;
    reg_wr          = 1'b0;
    dp.mem_addr_sel = 1'b0;
    dp.reg_dest     = 1'b0;
    dp.jal_sel_addr = 1'b0;
    dp.jal_sel_d    = 1'b0;
    dp.mem_to_reg   = 1'b0;
    dp.alu_src_a    = 1'b0;
    dp.alu_src_b    = SrcBRt;
    dp.pc_src       = PcAlu;
    alu_cmd         = AluAdd;
    unique case (state_q)
      StFetch: begin
        dp.alu_src_b = SrcBFour;
        ir_wr        = dp.mem_ready;
        pc_wr        = dp.mem_ready;
        if (dp.mem_ready)    state_d = StDecode;
        else if (mem_timeout) state_d = StTrap;
      end
      StDecode: begin
        dp.alu_src_b = SrcBImmSh;
        case (dp.opcode)
          OpRType: begin
            if (dp.funct == FnJr) state_d = StJr;
            else if (dp.funct == FnAdd || dp.funct == FnSub || dp.funct == FnSlt)
              state_d = StExecR;
            else state_d = StTrap;
          end
          OpAddi, OpXori: state_d = StExecI;
          OpLw, OpSw:     state_d = StMemAddr;
          OpBeq, OpBne:   state_d = StBranch;
          OpJ:            state_d = StJump;
          OpJal:          state_d = StJal;
          default:        state_d = StTrap;
        endcase
      end
      StExecR: begin
        dp.alu_src_a = 1'b1;
        case (dp.funct)
          FnSub:   alu_cmd = AluSub;
          FnSlt:   alu_cmd = AluSlt;
          default: alu_cmd = AluAdd;
        endcase
        state_d = StRwb;
      end
      StRwb: begin
        reg_wr      = 1'b1;
        dp.reg_dest = 1'b1;
        state_d     = StFetch;
      end
      StExecI: begin
        dp.alu_src_a = 1'b1;
        dp.alu_src_b = SrcBImm;
        alu_cmd      = (dp.opcode == OpXori) ? AluXor : AluAdd;
        state_d      = StIwb;
      end
      StIwb: begin
        reg_wr  = 1'b1;
        state_d = StFetch;
      end
      StMemAddr: begin
        dp.alu_src_a = 1'b1;
        dp.alu_src_b = SrcBImm;
        state_d      = (dp.opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        dp.mem_addr_sel = 1'b1;
        if (dp.mem_ready)    state_d = StLwb;
        else if (mem_timeout) state_d = StTrap;
      end
      StLwb: begin
        reg_wr        = 1'b1;
        dp.mem_to_reg = 1'b1;
        state_d       = StFetch;
      end
      StMemWr: begin
        dp.mem_addr_sel = 1'b1;
        mem_wr          = 1'b1;
        if (dp.mem_ready)    state_d = StFetch;
        else if (mem_timeout) state_d = StTrap;
      end
      StBranch: begin
        dp.alu_src_a = 1'b1;
        alu_cmd      = AluSub;
        dp.pc_src    = PcAluOut;
        pc_wr        = (dp.opcode == OpBne) ? !dp.zero : dp.zero;
        state_d      = StFetch;
      end
      StJump, StJal: begin
        pc_wr           = 1'b1;
        dp.pc_src       = PcJump;
        reg_wr          = (state_q == StJal);
        dp.jal_sel_addr = (state_q == StJal);
        dp.jal_sel_d    = (state_q == StJal);
        state_d         = StFetch;
      end
      StJr: begin
        pc_wr     = 1'b1;
        dp.pc_src = PcRs;
        state_d   = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  assign instr_done = (state_q != StFetch) && (state_d == StFetch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) retired_q <= retired_q + RET_CNT_W'(1);
    end
  end

  // Gate with reset_n so an abort kills any strobe without waiting for a clock edge.
  assign dp.pc_wr_en   = pc_wr & reset_n;
  assign dp.ir_wr_en   = ir_wr & reset_n;
  assign dp.mem_wr_en  = mem_wr & reset_n;
  assign dp.reg_wr_en  = reg_wr & reset_n;
  assign dp.alu_sel    = alu_cmd;
  assign dp.instr_done = instr_done;
  assign dp.trap       = (state_q == StTrap);
  assign dp.retired    = retired_q;
  assign dp.state_dbg  = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-scenario tasks with hand-computed
// expectations for state sequencing, strobes, retire count and trap paths.
module tb_multicycle_ctrl;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   exp_ret;

  multicycle_ctrl_if #(.RET_CNT_W(32)) bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT(16),
    .RET_CNT_W  (32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .dp     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.opcode = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({bus.pc_wr_en, bus.ir_wr_en, bus.reg_wr_en, bus.mem_wr_en} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_enables got=%b exp=0000",
               {bus.pc_wr_en, bus.ir_wr_en, bus.reg_wr_en, bus.mem_wr_en});
    end
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.trap !== 1'b0 || bus.retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%b/%0d exp=0/0/0", bus.state_dbg, bus.trap, bus.retired);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if ({bus.pc_wr_en, bus.ir_wr_en} !== 2'b11) begin
      failures++;
      $display("FAIL reset_release_fetch got=%b exp=11", {bus.pc_wr_en, bus.ir_wr_en});
    end
    exp_ret = 0;
  endtask

  task automatic test_rtype();
    bus.opcode = 6'b000000; bus.funct = 6'b100000; #1;
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.alu_src_b !== 2'b01 || bus.alu_sel !== 3'b000) begin
      failures++;
      $display("FAIL rtype_fetch got=%0d/%b/%b exp=0/01/000", bus.state_dbg, bus.alu_src_b,
               bus.alu_sel);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 4'd1 || bus.alu_src_b !== 2'b11 || bus.ir_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL rtype_decode got=%0d/%b/%b exp=1/11/0", bus.state_dbg, bus.alu_src_b,
               bus.ir_wr_en);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 4'd2 || {bus.alu_src_a, bus.alu_src_b, bus.alu_sel} !== 6'b100000) begin
      failures++;
      $display("FAIL rtype_exec got=%0d/%b exp=2/100000", bus.state_dbg,
               {bus.alu_src_a, bus.alu_src_b, bus.alu_sel});
    end
    tick();
    checks++;
    if (bus.state_dbg !== 4'd3 || {bus.reg_wr_en, bus.reg_dest, bus.mem_to_reg} !== 3'b110 ||
        bus.instr_done !== 1'b1 || bus.retired !== 32'd0) begin
      failures++;
      $display("FAIL rtype_rwb got=%0d/%b/%b/%0d exp=3/110/1/0", bus.state_dbg,
               {bus.reg_wr_en, bus.reg_dest, bus.mem_to_reg}, bus.instr_done, bus.retired);
    end
    tick();
    exp_ret = 1;
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== 32'd1 || bus.instr_done !== 1'b0) begin
      failures++;
      $display("FAIL rtype_retire got=%0d/%0d/%b exp=0/1/0", bus.state_dbg, bus.retired,
               bus.instr_done);
    end
  endtask

  task automatic test_lw_wait();
    bus.opcode = 6'b100011; #1;
    tick();
    tick();
    checks++;
    if (bus.state_dbg !== 4'd6 || {bus.alu_src_a, bus.alu_src_b, bus.alu_sel} !== 6'b110000) begin
      failures++;
      $display("FAIL lw_addr got=%0d/%b exp=6/110000", bus.state_dbg,
               {bus.alu_src_a, bus.alu_src_b, bus.alu_sel});
    end
    tick();
    bus.mem_ready = 1'b0; #1;
    checks++;
    if (bus.state_dbg !== 4'd7 || bus.mem_addr_sel !== 1'b1 || bus.reg_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL lw_memrd got=%0d/%b/%b exp=7/1/0", bus.state_dbg, bus.mem_addr_sel,
               bus.reg_wr_en);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.state_dbg !== 4'd7) begin
        failures++;
        $display("FAIL lw_hold%0d got=%0d exp=7", i, bus.state_dbg);
      end
    end
    bus.mem_ready = 1'b1;
    tick();
    checks++;
    if (bus.state_dbg !== 4'd8 || {bus.reg_wr_en, bus.reg_dest, bus.mem_to_reg} !== 3'b101 ||
        bus.instr_done !== 1'b1) begin
      failures++;
      $display("FAIL lw_lwb got=%0d/%b/%b exp=8/101/1", bus.state_dbg,
               {bus.reg_wr_en, bus.reg_dest, bus.mem_to_reg}, bus.instr_done);
    end
    tick();
    exp_ret = 2;
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== 32'd2) begin
      failures++;
      $display("FAIL lw_retire got=%0d/%0d exp=0/2", bus.state_dbg, bus.retired);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[3];
    logic       zs[3];
    logic       pcw[3];
    ops = '{6'b000101, 6'b000101, 6'b000100};
    zs  = '{1'b1, 1'b0, 1'b1};
    pcw = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = ops[i]; bus.zero = zs[i]; #1;
      tick();
      tick();
      checks++;
      if (bus.state_dbg !== 4'd10 || bus.pc_wr_en !== pcw[i] || bus.pc_src !== 2'b01 ||
          bus.alu_sel !== 3'b001 || bus.instr_done !== 1'b1) begin
        failures++;
        $display("FAIL branch%0d got=%0d/%b/%b/%b/%b exp=10/%b/01/001/1", i, bus.state_dbg,
                 bus.pc_wr_en, bus.pc_src, bus.alu_sel, bus.instr_done, pcw[i]);
      end
      tick();
      exp_ret++;
      checks++;
      if (bus.retired !== 32'(exp_ret)) begin
        failures++;
        $display("FAIL branch%0d_retire got=%0d exp=%0d", i, bus.retired, exp_ret);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jal();
    bus.opcode = 6'b000011; #1;
    tick();
    tick();
    checks++;
    if (bus.state_dbg !== 4'd12 || bus.pc_src !== 2'b10 || bus.ir_wr_en !== 1'b0 ||
        {bus.pc_wr_en, bus.reg_wr_en, bus.jal_sel_addr, bus.jal_sel_d} !== 4'b1111) begin
      failures++;
      $display("FAIL jal got=%0d/%b/%b/%b exp=12/10/0/1111", bus.state_dbg, bus.pc_src,
               bus.ir_wr_en, {bus.pc_wr_en, bus.reg_wr_en, bus.jal_sel_addr, bus.jal_sel_d});
    end
    tick();
    exp_ret++;
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== 32'(exp_ret)) begin
      failures++;
      $display("FAIL jal_retire got=%0d/%0d exp=0/%0d", bus.state_dbg, bus.retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid_memwr();
    bus.opcode = 6'b101011; #1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0; #1;
    checks++;
    if (bus.state_dbg !== 4'd9 || bus.mem_wr_en !== 1'b1 || bus.mem_addr_sel !== 1'b1) begin
      failures++;
      $display("FAIL sw_memwr got=%0d/%b/%b exp=9/1/1", bus.state_dbg, bus.mem_wr_en,
               bus.mem_addr_sel);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_wr_en !== 1'b0 || bus.state_dbg !== 4'd0 || bus.retired !== 32'd0) begin
      failures++;
      $display("FAIL async_abort got=%b/%0d/%0d exp=0/0/0", bus.mem_wr_en, bus.state_dbg,
               bus.retired);
    end
    bus.mem_ready = 1'b1;
    tick();
    checks++;
    if ({bus.pc_wr_en, bus.ir_wr_en} !== 2'b00) begin
      failures++;
      $display("FAIL reset_forced_low got=%b exp=00", {bus.pc_wr_en, bus.ir_wr_en});
    end
    reset_n = 1'b1;
    #1;
    exp_ret = 0;
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== 32'd0 || bus.ir_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_release got=%0d/%0d/%b exp=0/0/1", bus.state_dbg, bus.retired,
               bus.ir_wr_en);
    end
  endtask

  task automatic test_illegal();
    bus.opcode = 6'b111111; #1;
    tick();
    checks++;
    if (bus.state_dbg !== 4'd1 || bus.instr_done !== 1'b0) begin
      failures++;
      $display("FAIL illegal_decode got=%0d/%b exp=1/0", bus.state_dbg, bus.instr_done);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 4'd14 || bus.trap !== 1'b1 || bus.retired !== 32'(exp_ret)) begin
      failures++;
      $display("FAIL illegal_trap got=%0d/%b/%0d exp=14/1/%0d", bus.state_dbg, bus.trap,
               bus.retired, exp_ret);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 4'd14 ||
        {bus.pc_wr_en, bus.ir_wr_en, bus.reg_wr_en, bus.mem_wr_en} !== 4'b0000) begin
      failures++;
      $display("FAIL trap_absorb got=%0d/%b exp=14/0000", bus.state_dbg,
               {bus.pc_wr_en, bus.ir_wr_en, bus.reg_wr_en, bus.mem_wr_en});
    end
  endtask

  task automatic test_fetch_timeout();
    apply_reset();
    bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.state_dbg !== 4'd0 || bus.trap !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d got=%0d/%b exp=0/0", i, bus.state_dbg, bus.trap);
      end
      tick();
    end
    checks++;
    if (bus.state_dbg !== 4'd14 || bus.trap !== 1'b1) begin
      failures++;
      $display("FAIL timeout_trap got=%0d/%b exp=14/1", bus.state_dbg, bus.trap);
    end
  endtask

  task automatic test_ready_at_limit();
    apply_reset();
    bus.mem_ready = 1'b0; #1;
    for (int i = 0; i < 15; i++) tick();
    bus.mem_ready = 1'b1; #1;
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.ir_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL limit_fetch got=%0d/%b exp=0/1", bus.state_dbg, bus.ir_wr_en);
    end
    tick();
    checks++;
    if (bus.state_dbg !== 4'd1 || bus.trap !== 1'b0) begin
      failures++;
      $display("FAIL limit_ready_wins got=%0d/%b exp=1/0", bus.state_dbg, bus.trap);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_ret  = 0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_jal();
    test_reset_mid_memwr();
    test_illegal();
    test_fetch_timeout();
    test_ready_at_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore/Mealy control FSM that sequences a multicycle version of the MIPS-subset datapath. Fetch and data access share one memory port, so each instruction takes 3–5 cycles. The FSM drives every enable and select in the datapath: PC, IR, register-file write, memory write, operand muxes, ALU command and PC-source. It handshakes with memory via mem_ready, retires one instruction per completed sequence, and traps on illegal opcodes or memory timeout.

Parameters:
MEM_TIMEOUT, 16, consecutive cycles mem_ready may stay low in a memory state before trapping; 0 disables the timeout.
RET_CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_wr_en  out  1  PC register load
ir_wr_en  out  1  IR load
mem_addr_sel  out  1  memory address: 0=PC, 1=ALUOut
mem_wr_en  out  1  data write strobe
reg_wr_en  out  1  register-file write
reg_dest  out  1  write address: 0=rt, 1=rd
jal_sel_addr  out  1  force write address to 31
jal_sel_d  out  1  write data = PC (already PC+4)
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
alu_src_a  out  1  ALU A: 0=PC, 1=rs
alu_src_b  out  2  ALU B: 00=rt, 01=const 4, 10=sext imm, 11=sext imm<<2
alu_sel  out  3  ALU command
pc_src  out  2  PC next: 00=ALU result, 01=ALUOut, 10=jump target, 11=rs
instr_done  out  1  one-cycle pulse per retired instruction
trap  out  1  sticky fault flag
retired  out  RET_CNT_W  retired-instruction count
state_dbg  out  4  current state encoding

Behaviour:
Reset:
- reset_n low: state=FETCH, trap=0, retired=0, wait counter=0.
- While reset_n is low, all write enables (pc, ir, mem, reg) are forced to 0.
Encodings:
- ALU commands: ADD=000, SUB=001, XOR=010, SLT=011.
- Unlisted outputs in each state are 0 / ADD.
Supported instructions:
- R-type (op 000000): ADD f=100000, SUB f=100010, SLT f=101010, JR f=001000.
- ADDI 001000, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011.
States:
- FETCH: mem_addr_sel=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00. ir_wr_en=pc_wr_en=mem_ready. Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Dispatch: R (JR→JR, legal funct→EXEC_R), ADDI/XORI→EXEC_I, LW/SW→MEM_ADDR, BEQ/BNE→BRANCH, J→JUMP, JAL→JAL. Anything else (including an unlisted funct) → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_sel from funct → RWB.
- RWB: reg_wr_en=1, reg_dest=1, mem_to_reg=0 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ADD (ADDI) or XOR (XORI) → IWB.
- IWB: reg_wr_en=1, reg_dest=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_addr_sel=1; wait for mem_ready → LWB.
- LWB: reg_wr_en=1, reg_dest=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_addr_sel=1, mem_wr_en=1 held until mem_ready → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_wr_en=zero for BEQ, !zero for BNE → FETCH.
- JUMP: pc_wr_en=1, pc_src=10 → FETCH.
- JAL: as JUMP, plus reg_wr_en=1, jal_sel_addr=1, jal_sel_d=1 → FETCH.
- JR: pc_wr_en=1, pc_src=11 → FETCH.
- TRAP: all enables 0, trap=1. Absorbing until reset.
Latency (mem_ready tied 1):
- Branch, J, JAL, JR: 3 cycles.
- R-type, I-type, SW: 4 cycles.
- LW: 5 cycles.
instr_done / retired:
- instr_done pulses in the final cycle of each instruction (the cycle whose next state is FETCH). retired increments on that cycle.
- A not-taken branch still retires.
- retired wraps modulo 2^RET_CNT_W.
Wait timer:
- Counts consecutive !mem_ready cycles in FETCH, MEM_RD or MEM_WR; clears on mem_ready or on state change.
- When the count reaches MEM_TIMEOUT with mem_ready still low, next state is TRAP.
- mem_ready arriving in the same cycle as the limit wins: the access completes.
- Illegal opcode: DECODE → TRAP, no retire.
Reset mid-instruction:
- Aborts immediately. No partial write may follow, since enables are forced low asynchronously.

Decomposition:
- Package cpu_ctrl_pkg: opcode/funct constants, ALU command codes, state encoding, alu_src_b/pc_src select codes.
- One sub-module, mem_wait_timer: counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset, mem_ready=1, op=000000 f=100000 → states FETCH, DECODE, EXEC_R, RWB. reg_wr_en=1 and reg_dest=1 in cycle 4; instr_done pulse; retired=1.
- LW, mem_ready low 3 cycles in MEM_RD → state holds; LWB asserts mem_to_reg=1, reg_wr_en=1; 8 cycles total.
- BNE with zero=1 → pc_wr_en=0 in BRANCH. With zero=0 → pc_wr_en=1, pc_src=01. Both retire.
- JAL → cycle 3: pc_wr_en=1, pc_src=10, reg_wr_en=1, jal_sel_addr=1, jal_sel_d=1.
- op=111111 → TRAP after DECODE, trap=1, retired unchanged. mem_ready held low 16 cycles in FETCH (MEM_TIMEOUT=16) → TRAP.
- reset_n dropped mid-MEM_WR → mem_wr_en falls at once without waiting for clk; state=FETCH, retired=0 after release.
